ram: RTL and testbench

RAM -- requirements
Module: ram

---
 rtl/ram.sv | 42 ++++
 tb/tb_ram.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ram.sv
// Register-file RAM: 2^ADDR_W words of DATA_W bits, write on the rising clk edge,
// combinational read from a, every word cleared asynchronously while rst_n is low.
module ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] a,
  input  logic [DATA_W-1:0] d,
  input  logic              we,
  output logic [DATA_W-1:0] spo
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Each word is its own register with a private enable, so an undefined address
  // can only ever disturb the word it happens to decode to.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] word_reg;
      logic              hit;

      assign hit = we && (a == ADDR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (hit) begin
          word_reg <= d;
        end
      end

      assign mem[gi] = word_reg;
    end
  endgenerate

  assign spo = mem[a];

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: stimulus queues expected spo values, a monitor pops and
// compares them against the live read port.
module tb_ram;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic              we;
  logic [DATA_W-1:0] spo;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] exp_q[$];
  string             name_q[$];
  event              chk_ev;

  ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .d    (d),
    .we   (we),
    .spo  (spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue an expectation for the current inputs; the monitor compares it.
  task automatic expect_spo(input string name, input logic [DATA_W-1:0] value);
    exp_q.push_back(value);
    name_q.push_back(name);
    ->chk_ev;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [DATA_W-1:0] e;
    string n;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (spo !== e) begin
          errors++;
          $display("FAIL %s: a=%0d spo=0x%08h expected=0x%08h", n, a, spo, e);
        end else begin
          $display("ok   %s: a=%0d spo=0x%08h", n, a, spo);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    a     = '0;
    d     = '0;
    we    = 1'b0;
    #2;

    // Reset sweep: every address reads zero.
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      a = ADDR_W'(i);
      #1;
      expect_spo("reset_sweep", 32'h0);
    end

    // Write attempted while reset is held must be ignored.
    @(negedge clk);
    a = 6'd5; d = 32'hFFFF_FFFF; we = 1'b1;
    after_edge();
    expect_spo("write_in_reset", 32'h0);

    // Release reset, we=0 for several edges.
    @(negedge clk);
    we = 1'b0; rst_n = 1'b1; a = 6'd1; d = 32'd23;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      expect_spo("we0_no_write", 32'h0);
    end

    // Single write, then d/we changes without a write.
    @(negedge clk);
    we = 1'b1;
    after_edge();
    expect_spo("write_a1", 32'd23);
    @(negedge clk);
    we = 1'b0; d = 32'h0;
    #1;
    expect_spo("d_change_no_effect", 32'd23);
    after_edge();
    expect_spo("hold_a1", 32'd23);

    // Boundary addresses.
    @(negedge clk);
    a = 6'd63; d = 32'hDEAD_BEEF; we = 1'b1;
    @(negedge clk);
    a = 6'd0; d = 32'h1;
    @(negedge clk);
    we = 1'b0; d = 32'h1234_5678;
    a = 6'd63; #1; expect_spo("read_a63", 32'hDEAD_BEEF);
    a = 6'd0;  #1; expect_spo("read_a0", 32'h1);
    a = 6'd1;  #1; expect_spo("read_a1", 32'd23);

    // Read-during-write: old word before the edge, new word right after.
    @(negedge clk);
    a = 6'd2; d = 32'h0000_0055; we = 1'b1;
    #1;
    expect_spo("rdw_before", 32'h0);
    after_edge();
    expect_spo("rdw_after", 32'h0000_0055);

    // Back-to-back writes to the same address: last one wins.
    @(negedge clk);
    a = 6'd5; d = 32'hA; we = 1'b1;
    after_edge();
    expect_spo("b2b_first", 32'hA);
    @(negedge clk);
    d = 32'hB;
    after_edge();
    expect_spo("b2b_second", 32'hB);
    @(negedge clk);
    we = 1'b0; d = 32'hC;
    after_edge();
    expect_spo("b2b_hold", 32'hB);
    a = 6'd2; #1; expect_spo("neighbour_a2", 32'h0000_0055);

    // Asynchronous reset pulse between edges clears everything immediately.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    a = 6'd5;  #1; expect_spo("async_rst_a5", 32'h0);
    a = 6'd63; #1; expect_spo("async_rst_a63", 32'h0);
    a = 6'd1;  #1; expect_spo("async_rst_a1", 32'h0);
    a = 6'd7; d = 32'h77; we = 1'b1;
    after_edge();
    expect_spo("write_in_reset2", 32'h0);

    // First enabled edge after release performs a normal write.
    @(negedge clk);
    rst_n = 1'b1;
    after_edge();
    expect_spo("post_reset_write", 32'h77);
    @(negedge clk);
    we = 1'b0;
    a = 6'd5; #1; expect_spo("post_reset_a5", 32'h0);
    a = 6'd0; #1; expect_spo("post_reset_a0", 32'h0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
